// File: rtl/gpu_raster.sv
`default_nettype none
// gpu_raster: 3-stage edge-function rasterizer for two triangles (A, B) with depth resolve.
// Frontend state is snapshotted at frame_start; each pixel's result appears 3 edges after it is sampled.
module gpu_raster (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [6:0]  pix_x,
  input  logic [5:0]  pix_y,
  input  logic [5:0]  bg_color,
  input  logic [11:0] poly_color,
  input  logic [13:0] v0_x,
  input  logic [13:0] v1_x,
  input  logic [13:0] v2_x,
  input  logic [11:0] v0_y,
  input  logic [11:0] v1_y,
  input  logic [11:0] v2_y,
  input  logic [5:0]  poly_depth,
  input  logic        en_screen,
  input  logic [1:0]  poly_enable,
  output logic        out_valid,
  output logic [5:0]  out_color,
  output logic [1:0]  out_hit
);

  // Per-pixel attribute bundle: {en[26], pen[25:24], color[23:12], depth[11:6], bg[5:0]}
  localparam int ATTR_W = 27;
  localparam int ATTR3_W = 25;

  logic [5:0]  sh_bg_q;
  logic [11:0] sh_color_q;
  logic [13:0] sh_v0x_q, sh_v1x_q, sh_v2x_q;
  logic [11:0] sh_v0y_q, sh_v1y_q, sh_v2y_q;
  logic [5:0]  sh_depth_q;
  logic        sh_en_q;
  logic [1:0]  sh_pen_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_bg_q    <= '0;
      sh_color_q <= '0;
      sh_v0x_q   <= '0;
      sh_v1x_q   <= '0;
      sh_v2x_q   <= '0;
      sh_v0y_q   <= '0;
      sh_v1y_q   <= '0;
      sh_v2y_q   <= '0;
      sh_depth_q <= '0;
      sh_en_q    <= 1'b0;
      sh_pen_q   <= '0;
    end else if (frame_start) begin
      sh_bg_q    <= bg_color;
      sh_color_q <= poly_color;
      sh_v0x_q   <= v0_x;
      sh_v1x_q   <= v1_x;
      sh_v2x_q   <= v2_x;
      sh_v0y_q   <= v0_y;
      sh_v1y_q   <= v1_y;
      sh_v2y_q   <= v2_y;
      sh_depth_q <= poly_depth;
      sh_en_q    <= en_screen;
      sh_pen_q   <= poly_enable;
    end
  end

  function automatic logic signed [15:0] sx8(input logic signed [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic signed [15:0] sx7(input logic signed [6:0] v);
    return {{9{v[6]}}, v};
  endfunction

  logic [6:0] w_vx [2][3];
  logic [5:0] w_vy [2][3];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_vx[p][0] = sh_v0x_q[p*7 +: 7];
      w_vx[p][1] = sh_v1x_q[p*7 +: 7];
      w_vx[p][2] = sh_v2x_q[p*7 +: 7];
      w_vy[p][0] = sh_v0y_q[p*6 +: 6];
      w_vy[p][1] = sh_v1y_q[p*6 +: 6];
      w_vy[p][2] = sh_v2y_q[p*6 +: 6];
    end
  end

  // Stage 1: edge vectors and pixel offsets, zero-extended before subtracting so nothing wraps
  logic signed [7:0] s1_dx_d [2][3], s1_dx_q [2][3];
  logic signed [6:0] s1_dy_d [2][3], s1_dy_q [2][3];
  logic signed [7:0] s1_px_d [2][3], s1_px_q [2][3];
  logic signed [6:0] s1_py_d [2][3], s1_py_q [2][3];
  logic              s1_valid_q;
  logic [ATTR_W-1:0] s1_attr_q;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        s1_dx_d[p][i] = $signed({1'b0, w_vx[p][(i+1)%3]}) - $signed({1'b0, w_vx[p][i]});
        s1_dy_d[p][i] = $signed({1'b0, w_vy[p][(i+1)%3]}) - $signed({1'b0, w_vy[p][i]});
        s1_px_d[p][i] = $signed({1'b0, pix_x}) - $signed({1'b0, w_vx[p][i]});
        s1_py_d[p][i] = $signed({1'b0, pix_y}) - $signed({1'b0, w_vy[p][i]});
      end
    end
  end

  // Stage 2: edge functions and doubled signed area
  logic signed [15:0] s2_e_d [2][3], s2_e_q [2][3];
  logic signed [15:0] s2_area_d [2], s2_area_q [2];
  logic               s2_valid_q;
  logic [ATTR_W-1:0]  s2_attr_q;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        s2_e_d[p][i] = sx8(s1_px_q[p][i]) * sx7(s1_dy_q[p][i])
                     - sx7(s1_py_q[p][i]) * sx8(s1_dx_q[p][i]);
      end
      s2_area_d[p] = sx8(s1_dx_q[p][2]) * sx7(s1_dy_q[p][0])
                   - sx8(s1_dx_q[p][0]) * sx7(s1_dy_q[p][2]);
    end
  end

  // Stage 3: inclusive inside test accepting either winding
  logic [1:0]         w_ge, w_le;
  logic [1:0]         s3_cov_d, s3_cov_q;
  logic               s3_valid_q;
  logic [ATTR3_W-1:0] s3_attr_q;

  always_comb begin
    w_ge     = '0;
    w_le     = '0;
    s3_cov_d = '0;
    for (int p = 0; p < 2; p++) begin
      w_ge[p] = ~s2_e_q[p][0][15] & ~s2_e_q[p][1][15] & ~s2_e_q[p][2][15];
      w_le[p] = (s2_e_q[p][0][15] | (s2_e_q[p][0] == 16'sd0))
              & (s2_e_q[p][1][15] | (s2_e_q[p][1] == 16'sd0))
              & (s2_e_q[p][2][15] | (s2_e_q[p][2] == 16'sd0));
      s3_cov_d[p] = s2_attr_q[24+p] & (s2_area_q[p] != 16'sd0) & (w_ge[p] | w_le[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < 3; i++) begin
          s1_dx_q[p][i] <= '0;
          s1_dy_q[p][i] <= '0;
          s1_px_q[p][i] <= '0;
          s1_py_q[p][i] <= '0;
          s2_e_q[p][i]  <= '0;
        end
        s2_area_q[p] <= '0;
      end
      s1_valid_q <= 1'b0;
      s1_attr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_attr_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_attr_q  <= '0;
      s3_cov_q   <= '0;
    end else begin
      s1_dx_q    <= s1_dx_d;
      s1_dy_q    <= s1_dy_d;
      s1_px_q    <= s1_px_d;
      s1_py_q    <= s1_py_d;
      s1_valid_q <= pix_valid;
      s1_attr_q  <= {sh_en_q, sh_pen_q, sh_color_q, sh_depth_q, sh_bg_q};
      s2_e_q     <= s2_e_d;
      s2_area_q  <= s2_area_d;
      s2_valid_q <= s1_valid_q;
      s2_attr_q  <= s1_attr_q;
      s3_cov_q   <= s3_cov_d;
      s3_valid_q <= s2_valid_q;
      s3_attr_q  <= {s2_attr_q[26], s2_attr_q[23:0]};
    end
  end

  // Resolve: nearer depth wins, ties go to A; disabled screen blanks to 0
  logic       w_b_wins;
  logic       out_valid_d;
  logic [5:0] out_color_d;
  logic [1:0] out_hit_d;

  always_comb begin
    w_b_wins    = 1'b0;
    out_valid_d = s3_valid_q;
    out_color_d = '0;
    out_hit_d   = '0;
    if (s3_valid_q && s3_attr_q[24]) begin
      case (s3_cov_q)
        2'b01:   w_b_wins = 1'b0;
        2'b10:   w_b_wins = 1'b1;
        2'b11:   w_b_wins = (s3_attr_q[11:9] < s3_attr_q[8:6]);
        default: w_b_wins = 1'b0;
      endcase
      if (s3_cov_q == 2'b00) begin
        out_color_d = s3_attr_q[5:0];
      end else if (w_b_wins) begin
        out_color_d = s3_attr_q[23:18];
        out_hit_d   = 2'b10;
      end else begin
        out_color_d = s3_attr_q[17:12];
        out_hit_d   = 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_color <= '0;
      out_hit   <= '0;
    end else begin
      out_valid <= out_valid_d;
      out_color <= out_color_d;
      out_hit   <= out_hit_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpu_raster.sv
`default_nettype none
// tb_gpu_raster: directed self-checking bench for gpu_raster.
module tb_gpu_raster;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [6:0]  pix_x = '0;
  logic [5:0]  pix_y = '0;
  logic [5:0]  bg_color = '0;
  logic [11:0] poly_color = '0;
  logic [13:0] v0_x = '0, v1_x = '0, v2_x = '0;
  logic [11:0] v0_y = '0, v1_y = '0, v2_y = '0;
  logic [5:0]  poly_depth = '0;
  logic        en_screen = 1'b0;
  logic [1:0]  poly_enable = '0;
  logic        out_valid;
  logic [5:0]  out_color;
  logic [1:0]  out_hit;

  // {hit, color}
  localparam logic [7:0] EXP_A  = {2'b01, 6'h30};
  localparam logic [7:0] EXP_B  = {2'b10, 6'h0C};
  localparam logic [7:0] EXP_BG = {2'b00, 6'h05};

  int n_checks = 0;
  int n_fail   = 0;

  gpu_raster dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .bg_color    (bg_color),
    .poly_color  (poly_color),
    .v0_x        (v0_x),
    .v1_x        (v1_x),
    .v2_x        (v2_x),
    .v0_y        (v0_y),
    .v1_y        (v1_y),
    .v2_y        (v2_y),
    .poly_depth  (poly_depth),
    .en_screen   (en_screen),
    .poly_enable (poly_enable),
    .out_valid   (out_valid),
    .out_color   (out_color),
    .out_hit     (out_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_pix(input logic [6:0] x, input logic [5:0] y,
                          output logic v, output logic [5:0] c, output logic [1:0] h);
    @(negedge clk);
    pix_x = x; pix_y = y; pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    v = out_valid; c = out_color; h = out_hit;
  endtask

  task automatic set_poly(input int p, input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input logic [5:0] col, input logic [2:0] dep);
    v0_x[p*7 +: 7] = 7'(x0); v0_y[p*6 +: 6] = 6'(y0);
    v1_x[p*7 +: 7] = 7'(x1); v1_y[p*6 +: 6] = 6'(y1);
    v2_x[p*7 +: 7] = 7'(x2); v2_y[p*6 +: 6] = 6'(y2);
    poly_color[p*6 +: 6] = col;
    poly_depth[p*3 +: 3] = dep;
  endtask

  task automatic pulse_frame();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic test_reset();
    logic v; logic [5:0] c; logic [1:0] h;
    rst_n = 1'b0; pix_valid = 1'b1; pix_x = 7'd20; pix_y = 6'd20;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({out_valid, out_hit, out_color} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got valid=%b hit=%b color=%h expected all zero", out_valid, out_hit, out_color);
    end
    rst_n = 1'b1; pix_valid = 1'b0;
    send_pix(7'd20, 6'd20, v, c, h);
    n_checks++;
    if ({v, h, c} !== {1'b1, 2'b00, 6'h00}) begin
      n_fail++;
      $display("FAIL reset_screen_off: got valid=%b hit=%b color=%h expected valid=1 hit=00 color=00", v, h, c);
    end
  endtask

  task automatic run_point_table(input string tag);
    int px[7] = '{20, 60, 10, 30, 30, 30, 9};
    int py[7] = '{20, 60, 10, 10, 25, 26, 20};
    logic [7:0] ex[7] = '{EXP_A, EXP_BG, EXP_A, EXP_A, EXP_A, EXP_BG, EXP_BG};
    logic v; logic [5:0] c; logic [1:0] h;
    for (int k = 0; k < 7; k++) begin
      send_pix(7'(px[k]), 6'(py[k]), v, c, h);
      n_checks++;
      if ({v, h, c} !== {1'b1, ex[k]}) begin
        n_fail++;
        $display("FAIL %s_pt(%0d,%0d): got valid=%b hit=%b color=%h expected valid=1 hit=%b color=%h",
                 tag, px[k], py[k], v, h, c, ex[k][7:6], ex[k][5:0]);
      end
    end
  endtask

  task automatic test_single_triangle();
    bg_color = 6'h05; en_screen = 1'b1; poly_enable = 2'b01;
    set_poly(0, 10, 10, 50, 10, 10, 40, 6'h30, 3'd2);
    pulse_frame();
    @(negedge clk);
    pix_x = 7'd20; pix_y = 6'd20; pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got valid=%b expected 0 after two edges", out_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_hit, out_color} !== {1'b1, EXP_A}) begin
      n_fail++;
      $display("FAIL latency_3: got valid=%b hit=%b color=%h expected valid=1 hit=01 color=30", out_valid, out_hit, out_color);
    end
    run_point_table("cw");
  endtask

  task automatic test_reversed();
    set_poly(0, 10, 10, 10, 40, 50, 10, 6'h30, 3'd2);
    pulse_frame();
    run_point_table("ccw");
  endtask

  task automatic test_overlap();
    logic v; logic [5:0] c; logic [1:0] h;
    set_poly(0, 10, 10, 50, 10, 10, 40, 6'h30, 3'd2);
    set_poly(1, 10, 10, 50, 10, 10, 40, 6'h0C, 3'd1);
    poly_enable = 2'b11;
    pulse_frame();
    send_pix(7'd20, 6'd20, v, c, h);
    n_checks++;
    if ({v, h, c} !== {1'b1, EXP_B}) begin
      n_fail++;
      $display("FAIL overlap_b_nearer: got valid=%b hit=%b color=%h expected valid=1 hit=10 color=0c", v, h, c);
    end
    send_pix(7'd60, 6'd60, v, c, h);
    n_checks++;
    if ({v, h, c} !== {1'b1, EXP_BG}) begin
      n_fail++;
      $display("FAIL overlap_outside: got valid=%b hit=%b color=%h expected valid=1 hit=00 color=05", v, h, c);
    end
    poly_depth[5:3] = 3'd2;
    pulse_frame();
    send_pix(7'd20, 6'd20, v, c, h);
    n_checks++;
    if ({v, h, c} !== {1'b1, EXP_A}) begin
      n_fail++;
      $display("FAIL overlap_tie: got valid=%b hit=%b color=%h expected valid=1 hit=01 color=30", v, h, c);
    end
    poly_depth[5:3] = 3'd3;
    pulse_frame();
    send_pix(7'd20, 6'd20, v, c, h);
    n_checks++;
    if ({v, h, c} !== {1'b1, EXP_A}) begin
      n_fail++;
      $display("FAIL overlap_a_nearer: got valid=%b hit=%b color=%h expected valid=1 hit=01 color=30", v, h, c);
    end
  endtask

  task automatic test_snapshot();
    logic v; logic [5:0] c; logic [1:0] h;
    poly_enable = 2'b01;
    pulse_frame();
    poly_color[5:0] = 6'h3F;
    send_pix(7'd20, 6'd20, v, c, h);
    n_checks++;
    if ({v, h, c} !== {1'b1, EXP_A}) begin
      n_fail++;
      $display("FAIL snapshot_hold: got valid=%b hit=%b color=%h expected valid=1 hit=01 color=30", v, h, c);
    end
    @(negedge clk);
    frame_start = 1'b1; pix_valid = 1'b1; pix_x = 7'd20; pix_y = 6'd20;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, out_hit, out_color} !== {1'b1, EXP_A}) begin
      n_fail++;
      $display("FAIL snapshot_same_edge: got valid=%b hit=%b color=%h expected valid=1 hit=01 color=30", out_valid, out_hit, out_color);
    end
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_hit, out_color} !== {1'b1, 2'b01, 6'h3F}) begin
      n_fail++;
      $display("FAIL snapshot_next_edge: got valid=%b hit=%b color=%h expected valid=1 hit=01 color=3f", out_valid, out_hit, out_color);
    end
  endtask

  task automatic test_degenerate_disabled();
    logic v; logic [5:0] c; logic [1:0] h;
    set_poly(0, 0, 0, 20, 20, 40, 40, 6'h30, 3'd2);
    pulse_frame();
    send_pix(7'd10, 6'd10, v, c, h);
    n_checks++;
    if ({v, h, c} !== {1'b1, EXP_BG}) begin
      n_fail++;
      $display("FAIL degenerate: got valid=%b hit=%b color=%h expected valid=1 hit=00 color=05", v, h, c);
    end
    set_poly(0, 10, 10, 50, 10, 10, 40, 6'h30, 3'd2);
    poly_enable = 2'b00;
    pulse_frame();
    send_pix(7'd20, 6'd20, v, c, h);
    n_checks++;
    if ({v, h, c} !== {1'b1, EXP_BG}) begin
      n_fail++;
      $display("FAIL poly_disabled: got valid=%b hit=%b color=%h expected valid=1 hit=00 color=05", v, h, c);
    end
    poly_enable = 2'b01; en_screen = 1'b0;
    pulse_frame();
    send_pix(7'd20, 6'd20, v, c, h);
    n_checks++;
    if ({v, h, c} !== {1'b1, 2'b00, 6'h00}) begin
      n_fail++;
      $display("FAIL screen_disabled: got valid=%b hit=%b color=%h expected valid=1 hit=00 color=00", v, h, c);
    end
    en_screen = 1'b1;
    pulse_frame();
    @(negedge clk);
    pix_x = 7'd20; pix_y = 6'd20; pix_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({out_valid, out_hit, out_color} !== 9'b0) begin
      n_fail++;
      $display("FAIL invalid_pixel: got valid=%b hit=%b color=%h expected all zero", out_valid, out_hit, out_color);
    end
  endtask

  task automatic test_back_to_back();
    int n_valid = 0, run = 0, max_run = 0, n_hit_a = 0;
    for (int cyc = 0; cyc < 134; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        n_valid++; run++;
        if (run > max_run) max_run = run;
        if (out_hit === 2'b01) n_hit_a++;
      end else begin
        run = 0;
      end
      if (cyc < 128) begin
        pix_valid = 1'b1; pix_x = 7'(cyc); pix_y = 6'd20;
      end else begin
        pix_valid = 1'b0;
      end
    end
    n_checks++;
    if (n_valid != 128) begin
      n_fail++;
      $display("FAIL stream_count: got %0d valid outputs expected 128", n_valid);
    end
    n_checks++;
    if (max_run != 128) begin
      n_fail++;
      $display("FAIL stream_run: got longest valid run %0d expected 128", max_run);
    end
    n_checks++;
    if (n_hit_a != 27) begin
      n_fail++;
      $display("FAIL stream_hits: got %0d A hits on row 20 expected 27", n_hit_a);
    end
  endtask

  task automatic test_midstream_reset();
    @(negedge clk);
    pix_valid = 1'b1; pix_x = 7'd20; pix_y = 6'd20;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({out_valid, out_hit, out_color} !== {1'b1, EXP_A}) begin
      n_fail++;
      $display("FAIL midreset_pre: got valid=%b hit=%b color=%h expected valid=1 hit=01 color=30", out_valid, out_hit, out_color);
    end
    rst_n = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_hit, out_color} !== 9'b0) begin
      n_fail++;
      $display("FAIL midreset_flush: got valid=%b hit=%b color=%h expected all zero", out_valid, out_hit, out_color);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_discard_%0d: got valid=%b expected 0", k, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_triangle();
    test_reversed();
    test_overlap();
    test_snapshot();
    test_degenerate_disabled();
    test_back_to_back();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
